// File: rtl/dispatch_ctrl_pkg.sv
// Shared ROB sizing, wrap-flag pointer type and pointer arithmetic helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dispatch_ctrl_pkg;

    localparam int ROB_SIZE     = 64;
    localparam int ROB_SIZE_LOG = 6;

    // ROB pointer: the wrap flag sits above the index, so plain binary
    // arithmetic on the packed value is already modulo 2*ROB_SIZE.
    typedef struct packed {
        logic                    flag;
        logic [ROB_SIZE_LOG-1:0] idx;
    } robptr_t;

    // Occupancy needs one extra bit to represent a completely full ROB.
    typedef logic [ROB_SIZE_LOG:0] rob_cnt_t;

    // Advance a pointer by 0..3 entries.
    function automatic robptr_t ptr_inc(input robptr_t p, input logic [1:0] n);
        logic [ROB_SIZE_LOG:0] sum;
        sum = p + {{(ROB_SIZE_LOG-1){1'b0}}, n};
        return robptr_t'(sum);
    endfunction

    // Entries from b up to (not including) a; equal index with differing
    // flags yields ROB_SIZE.
    function automatic rob_cnt_t ptr_dist(input robptr_t a, input robptr_t b);
        logic [ROB_SIZE_LOG:0] diff;
        diff = a - b;
        return rob_cnt_t'(diff);
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Dispatch-stage handshake bundle between rename/ROB side and the controller.
// Latency: n/a (wires only).
// Backpressure: ready signals flow back from the controller to rename.
interface dispatch_ctrl_if
    import dispatch_ctrl_pkg::*;
();

    logic                    instr0_valid;
    logic                    instr1_valid;
    logic                    instr0_ready;
    logic                    instr1_ready;
    logic                    iq0_ready;
    logic                    iq1_ready;
    logic                    to_issue_instr0_valid;
    logic                    to_issue_instr1_valid;
    logic                    to_issue_instr0_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] to_issue_instr0_robidx;
    logic                    to_issue_instr1_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] to_issue_instr1_robidx;
    logic [1:0]              commit_cnt;
    logic                    flush_valid;
    logic                    flush_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] flush_robidx;
    logic [ROB_SIZE_LOG:0]   counter;
    logic                    enq_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] enq_robidx;

    // Environment view: rename, issue queues, commit and redirect logic.
    modport master (
        output instr0_valid, instr1_valid, iq0_ready, iq1_ready,
               commit_cnt, flush_valid, flush_robidx_flag, flush_robidx,
        input  instr0_ready, instr1_ready,
               to_issue_instr0_valid, to_issue_instr1_valid,
               to_issue_instr0_robidx_flag, to_issue_instr0_robidx,
               to_issue_instr1_robidx_flag, to_issue_instr1_robidx,
               counter, enq_robidx_flag, enq_robidx
    );

    // Controller view.
    modport slave (
        input  instr0_valid, instr1_valid, iq0_ready, iq1_ready,
               commit_cnt, flush_valid, flush_robidx_flag, flush_robidx,
        output instr0_ready, instr1_ready,
               to_issue_instr0_valid, to_issue_instr1_valid,
               to_issue_instr0_robidx_flag, to_issue_instr0_robidx,
               to_issue_instr1_robidx_flag, to_issue_instr1_robidx,
               counter, enq_robidx_flag, enq_robidx
    );

endinterface

// File: rtl/dispatch_ctrl_rob_ptr_reg.sv
// Wrap-flag ROB pointer register with increment (0..3) and parallel load.
// Latency: 1 cycle from inc/load to ptr.
// Backpressure: none; load takes priority over increment.
module dispatch_ctrl_rob_ptr_reg
    import dispatch_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] inc,
    input  logic       load,
    input  robptr_t    load_val,
    output robptr_t    ptr
);

    // Pointer state: clear on reset, load on redirect, else advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else begin
            ptr <= ptr_inc(ptr, inc);
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Two-wide in-order dispatch sequencer owning ROB enq/deq pointers and occupancy.
// Latency: dispatch handshake and robidx are combinational; pointers/counter update next cycle.
// Backpressure: slot0 stalls on issue-queue, ROB full or flush; slot1 also needs slot0 and 2 free entries. Optional DISPATCH_PERF_EN adds stall counters.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    dispatch_ctrl_if.slave dif
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]    perf_rob_full_stall,
    output logic [31:0]    perf_iq_stall
`endif
);

    robptr_t  enq_ptr;
    robptr_t  deq_ptr;
    robptr_t  deq_ptr_nxt;
    robptr_t  flush_ptr;
    robptr_t  slot1_ptr;
    rob_cnt_t counter_q;
    rob_cnt_t counter_nxt;
    rob_cnt_t free;
    logic     rdy0;
    logic     rdy1;
    logic     fire0;
    logic     fire1;
    logic [1:0] n_disp;

    assign flush_ptr = '{flag: dif.flush_robidx_flag, idx: dif.flush_robidx};

    // Free space is taken from the start-of-cycle count, so a commit in the
    // same cycle never opens room for a dispatch.
    assign free = rob_cnt_t'(ROB_SIZE) - counter_q;

    // Ready terms include reset_n so every output reads 0 while in reset.
    assign rdy0  = reset_n & dif.iq0_ready & (free != '0) & ~dif.flush_valid;
    assign rdy1  = rdy0 & dif.instr0_valid & dif.iq1_ready & (free >= rob_cnt_t'(2));
    assign fire0 = dif.instr0_valid & rdy0;
    assign fire1 = dif.instr1_valid & rdy1;
    assign n_disp = {1'b0, fire0} + {1'b0, fire1};

    // Commits retire regardless of a redirect; the flush distance is then
    // measured from the post-commit dequeue pointer.
    assign deq_ptr_nxt = ptr_inc(deq_ptr, dif.commit_cnt);
    assign slot1_ptr   = ptr_inc(enq_ptr, 2'd1);

    dispatch_ctrl_rob_ptr_reg u_enq_ptr (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (n_disp),
        .load     (dif.flush_valid),
        .load_val (flush_ptr),
        .ptr      (enq_ptr)
    );

    dispatch_ctrl_rob_ptr_reg u_deq_ptr (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (dif.commit_cnt),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (deq_ptr)
    );

    // Next occupancy: rebuilt from pointers on flush, else dispatch minus commit.
    always_comb begin
        counter_nxt = counter_q;
        if (dif.flush_valid) begin
            counter_nxt = ptr_dist(flush_ptr, deq_ptr_nxt);
        end else begin
            counter_nxt = counter_q + rob_cnt_t'(n_disp) - rob_cnt_t'(dif.commit_cnt);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_nxt;
        end
    end

    assign dif.instr0_ready                = rdy0;
    assign dif.instr1_ready                = rdy1;
    assign dif.to_issue_instr0_valid       = fire0;
    assign dif.to_issue_instr1_valid       = fire1;
    assign dif.to_issue_instr0_robidx_flag = reset_n & enq_ptr.flag;
    assign dif.to_issue_instr0_robidx      = reset_n ? enq_ptr.idx : '0;
    assign dif.to_issue_instr1_robidx_flag = reset_n & slot1_ptr.flag;
    assign dif.to_issue_instr1_robidx      = reset_n ? slot1_ptr.idx : '0;
    assign dif.counter                     = counter_q;
    assign dif.enq_robidx_flag             = enq_ptr.flag;
    assign dif.enq_robidx                  = enq_ptr.idx;

`ifdef DISPATCH_PERF_EN
    // Saturating stall counters for ROB-full and issue-queue backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_rob_full_stall <= '0;
            perf_iq_stall       <= '0;
        end else begin
            if (dif.instr0_valid && (free == '0) && (perf_rob_full_stall != '1)) begin
                perf_rob_full_stall <= perf_rob_full_stall + 32'd1;
            end
            if (dif.instr0_valid && !dif.iq0_ready && (perf_iq_stall != '1)) begin
                perf_iq_stall <= perf_iq_stall + 32'd1;
            end
        end
    end
`endif

    // Protocol checks on the environment; these only fire on illegal stimulus.
    a_slot_order : assert property (@(posedge clock) disable iff (!reset_n)
        dif.instr1_valid |-> dif.instr0_valid);
    a_commit_max : assert property (@(posedge clock) disable iff (!reset_n)
        dif.commit_cnt != 2'd3);
    a_commit_occ : assert property (@(posedge clock) disable iff (!reset_n)
        rob_cnt_t'(dif.commit_cnt) <= counter_q);
    a_flush_rng  : assert property (@(posedge clock) disable iff (!reset_n)
        dif.flush_valid |-> (ptr_dist(flush_ptr, deq_ptr) <= counter_q));

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: reset, dual dispatch, wrap, full, flush, stall.
// Latency: inputs driven on falling edge, checked 1 time unit later and after the rising edge.
// Backpressure: exercised through iq readiness, ROB full and flush.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    dispatch_ctrl_if dif ();

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_rob_full_stall;
    logic [31:0] perf_iq_stall;
`endif

    dispatch_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .dif     (dif)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_rob_full_stall (perf_rob_full_stall),
        .perf_iq_stall       (perf_iq_stall)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {instr0_ready, instr1_ready, to_issue0_valid, to_issue1_valid}
    function automatic logic [31:0] hs();
        return {28'd0, dif.instr0_ready, dif.instr1_ready,
                dif.to_issue_instr0_valid, dif.to_issue_instr1_valid};
    endfunction

    function automatic logic [31:0] slot0();
        return {25'd0, dif.to_issue_instr0_robidx_flag, dif.to_issue_instr0_robidx};
    endfunction

    function automatic logic [31:0] slot1();
        return {25'd0, dif.to_issue_instr1_robidx_flag, dif.to_issue_instr1_robidx};
    endfunction

    // {counter, enq flag, enq idx}
    function automatic logic [31:0] state();
        return {18'd0, dif.counter, dif.enq_robidx_flag, dif.enq_robidx};
    endfunction

    function automatic logic [31:0] st(input int c, input logic f, input int ix);
        return {18'd0, 7'(c), f, 6'(ix)};
    endfunction

    function automatic logic [31:0] ptr(input logic f, input int ix);
        return {25'd0, f, 6'(ix)};
    endfunction

    task automatic drive(input logic v0, input logic v1, input logic q0, input logic q1,
                         input logic [1:0] cc, input logic fv, input logic ff, input int fi);
        dif.instr0_valid      = v0;
        dif.instr1_valid      = v1;
        dif.iq0_ready         = q0;
        dif.iq1_ready         = q1;
        dif.commit_cnt        = cc;
        dif.flush_valid       = fv;
        dif.flush_robidx_flag = ff;
        dif.flush_robidx      = 6'(fi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 2'd0, 0, 0, 0);

        // Reset held with random inputs: every output stays 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            dif.instr0_valid      = 1'($urandom);
            dif.instr1_valid      = 1'($urandom);
            dif.iq0_ready         = 1'($urandom);
            dif.iq1_ready         = 1'($urandom);
            dif.commit_cnt        = 2'($urandom);
            dif.flush_valid       = 1'($urandom);
            dif.flush_robidx_flag = 1'($urandom);
            dif.flush_robidx      = 6'($urandom);
            #1;
            check("rst_hs", hs(), 32'd0);
            check("rst_slot0", slot0(), 32'd0);
            check("rst_slot1", slot1(), 32'd0);
            check("rst_state", state(), 32'd0);
        end

        @(negedge clock);
        drive(0, 0, 1, 1, 2'd0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        // Empty ROB, slot0 idle: instr0 ready, instr1 not (no instr0_valid).
        check("idle_hs", hs(), 32'b1000);
        @(posedge clock); #1;
        check("idle_state", state(), st(0, 0, 0));

        // Ten dual dispatches: pairs (0,1) .. (18,19).
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
            #1;
            check("dual_hs", hs(), 32'b1111);
            check("dual_slot0", slot0(), ptr(0, 2 * i));
            check("dual_slot1", slot1(), ptr(0, 2 * i + 1));
            @(posedge clock); #1;
        end
        check("dual_state", state(), st(20, 0, 20));

        // Single dispatch on slot0 only; slot1 is still offered ready.
        @(negedge clock);
        drive(1, 0, 1, 1, 2'd0, 0, 0, 0);
        #1;
        check("single_hs", hs(), 32'b1110);
        check("single_slot0", slot0(), ptr(0, 20));
        @(posedge clock); #1;
        check("single_state", state(), st(21, 0, 21));

        // Dispatch 2 and commit 2 per cycle: counter flat, enq advances by 2.
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            drive(1, 1, 1, 1, 2'd2, 0, 0, 0);
            #1;
            check("steady_slot0", slot0(), ptr(0, 21 + 2 * i));
            @(posedge clock); #1;
            check("steady_state", state(), st(21, 0, 23 + 2 * i));
        end

        // Wrap: enq at 63 -> slots {0,63} and {1,0}, enq becomes {1,1}.
        @(negedge clock);
        drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
        #1;
        check("wrap_hs", hs(), 32'b1111);
        check("wrap_slot0", slot0(), ptr(0, 63));
        check("wrap_slot1", slot1(), ptr(1, 0));
        @(posedge clock); #1;
        check("wrap_state", state(), st(23, 1, 1));

        // Fill to 63 entries (deq is {0,42}).
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
            @(posedge clock); #1;
        end
        check("fill_state", state(), st(63, 1, 41));

        // One free entry: only slot0 goes.
        @(negedge clock);
        drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
        #1;
        check("last_hs", hs(), 32'b1010);
        @(posedge clock); #1;
        check("last_state", state(), st(64, 1, 42));

        // Full: nothing ready; a same-cycle commit of 2 still drains.
        @(negedge clock);
        drive(1, 1, 1, 1, 2'd2, 0, 0, 0);
        #1;
        check("full_hs", hs(), 32'b0000);
        @(posedge clock); #1;
        check("full_state", state(), st(62, 1, 42));

        // Mid-operation reset clears state without waiting for a clock.
        @(negedge clock);
        drive(0, 0, 1, 1, 2'd0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_state", state(), 32'd0);
        check("midrst_hs", hs(), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Build deq={0,10}, enq={0,30}.
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
            @(posedge clock); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(0, 0, 1, 1, 2'd2, 0, 0, 0);
            @(posedge clock); #1;
        end
        check("preflush_state", state(), st(20, 0, 30));

        // Flush at {0,20} with one commit: no dispatch, counter = 20 - 11.
        @(negedge clock);
        drive(1, 1, 1, 1, 2'd1, 1, 0, 20);
        #1;
        check("flush_hs", hs(), 32'b0000);
        @(posedge clock); #1;
        check("flush_state", state(), st(9, 0, 20));

        // In-order stall: slot0 blocked by its queue blocks slot1 too.
        @(negedge clock);
        drive(1, 1, 0, 1, 2'd0, 0, 0, 0);
        #1;
        check("stall_hs", hs(), 32'b0000);
        @(posedge clock); #1;
        check("stall_state", state(), st(9, 0, 20));

        // Resume after the flush from the rewound pointer.
        @(negedge clock);
        drive(1, 1, 1, 1, 2'd0, 0, 0, 0);
        #1;
        check("resume_hs", hs(), 32'b1111);
        check("resume_slot0", slot0(), ptr(0, 20));
        check("resume_slot1", slot1(), ptr(0, 21));
        @(posedge clock); #1;
        check("resume_state", state(), st(11, 0, 22));

        @(negedge clock);
        drive(0, 0, 0, 0, 2'd0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
